// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic inter-stage pipeline register with a 2-entry skid
// buffer, valid/ready handshake, synchronous flush and control zeroing on
// bubbles. Optional performance counters are enabled by defining
// PIPE_STAGE_PERF_EN; otherwise stall_cnt and flush_cnt are tied to zero.
module pipe_stage_reg #(
    parameter int DATA_W = 16,
    parameter int CTRL_W = 11,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    // Main entry drives the outputs; skid entry catches the one extra
    // instruction that can arrive while in_ready is still high after a stall.
    logic              mainValidReg;
    logic [DATA_W-1:0] mainDataReg;
    logic [CTRL_W-1:0] mainCtrlReg;
    logic              skidValidReg;
    logic [DATA_W-1:0] skidDataReg;
    logic [CTRL_W-1:0] skidCtrlReg;

    logic accept;
    logic pop;

    // in_ready comes straight from a flop, so there is no input-to-output
    // combinational path through this stage.
    assign in_ready  = !skidValidReg;
    assign out_valid = mainValidReg;
    assign out_data  = mainDataReg;
    assign out_ctrl  = mainValidReg ? mainCtrlReg : '0;
    assign occupancy = {1'b0, mainValidReg} + {1'b0, skidValidReg};

    assign accept = in_valid & in_ready & !flush;
    assign pop    = mainValidReg & out_ready;

    // Entry storage: flush wins over everything, otherwise FIFO fill/drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mainValidReg <= 1'b0;
            mainDataReg  <= '0;
            mainCtrlReg  <= '0;
            skidValidReg <= 1'b0;
            skidDataReg  <= '0;
            skidCtrlReg  <= '0;
        end else if (flush) begin
            // Bubble insertion: drop both entries and neutralise controls.
            mainValidReg <= 1'b0;
            mainCtrlReg  <= '0;
            skidValidReg <= 1'b0;
            skidCtrlReg  <= '0;
        end else if (!mainValidReg) begin
            if (accept) begin
                mainValidReg <= 1'b1;
                mainDataReg  <= in_data;
                mainCtrlReg  <= in_ctrl;
            end
        end else if (pop) begin
            if (skidValidReg) begin
                // Skid drains into main; in_ready was low so nothing new arrives.
                mainDataReg  <= skidDataReg;
                mainCtrlReg  <= skidCtrlReg;
                skidValidReg <= 1'b0;
                skidCtrlReg  <= '0;
            end else if (accept) begin
                mainDataReg  <= in_data;
                mainCtrlReg  <= in_ctrl;
            end else begin
                mainValidReg <= 1'b0;
                mainCtrlReg  <= '0;
            end
        end else if (accept) begin
            // Downstream stalled but we had advertised ready: park in skid.
            skidValidReg <= 1'b1;
            skidDataReg  <= in_data;
            skidCtrlReg  <= in_ctrl;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    // Index 0 counts stall cycles, index 1 counts flushes that killed work.
    logic [1:0]       cntInc;
    logic [CNT_W-1:0] cntReg [2];

    assign cntInc[0] = mainValidReg & !out_ready;
    assign cntInc[1] = flush & (mainValidReg | skidValidReg);

    for (genvar gi = 0; gi < 2; gi++) begin : g_perf_cnt
        // Saturating event counter.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cntReg[gi] <= '0;
            end else if (cntInc[gi] && (cntReg[gi] != {CNT_W{1'b1}})) begin
                cntReg[gi] <= cntReg[gi] + 1'b1;
            end
        end
    end

    assign stall_cnt = cntReg[0];
    assign flush_cnt = cntReg[1];
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: directed stimulus with a scoreboard queue.
// Counter checks are active when PIPE_STAGE_PERF_EN is defined.
module tb_pipe_stage_reg;

    localparam int DATA_W = 16;
    localparam int CTRL_W = 11;
    localparam int CNT_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    typedef struct packed {
        logic [CTRL_W-1:0] c;
        logic [DATA_W-1:0] d;
    } ent_t;

    ent_t q[$];
    int   expOcc;
    int   expStall;
    int   expFlush;
    int   checks;
    int   errors;

    pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_ctrl  (in_ctrl),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_ctrl (out_ctrl),
        .occupancy(occupancy),
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        q.delete();
        expOcc   = 0;
        expStall = 0;
        expFlush = 0;
    endtask

    // Check current outputs against the model, advance the model for the
    // inputs now driven, then step one clock (sampling 1 time unit later).
    task automatic tick();
        logic expInReady;
        logic expOutValid;
        logic acc;
        logic pp;
        ent_t e;
        expInReady  = (expOcc < 2);
        expOutValid = (expOcc != 0);
        chk("occupancy", 32'(occupancy), 32'(expOcc));
        chk("in_ready", 32'(in_ready), 32'(expInReady));
        chk("out_valid", 32'(out_valid), 32'(expOutValid));
        if (!expOutValid) chk("out_ctrl_mask", 32'(out_ctrl), 32'd0);
        chk("stall_cnt", 32'(stall_cnt), 32'(expStall));
        chk("flush_cnt", 32'(flush_cnt), 32'(expFlush));
        pp  = expOutValid && out_ready;
        acc = in_valid && expInReady && !flush;
        if (flush) begin
`ifdef PIPE_STAGE_PERF_EN
            if (expOcc != 0 && expFlush < CMAX) expFlush++;
`endif
            q.delete();
            expOcc = 0;
        end else begin
            if (pp) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL sb_empty observed=%h expected=none", out_data);
                end else begin
                    e = q.pop_front();
                    chk("out_data", 32'(out_data), 32'(e.d));
                    chk("out_ctrl", 32'(out_ctrl), 32'(e.c));
                    $display("pop data=%h ctrl=%h t=%0t", out_data, out_ctrl, $time);
                end
            end
            if (acc) begin
                e.c = in_ctrl;
                e.d = in_data;
                q.push_back(e);
                $display("push data=%h ctrl=%h t=%0t", in_data, in_ctrl, $time);
            end
            expOcc = expOcc + int'(acc) - int'(pp);
        end
`ifdef PIPE_STAGE_PERF_EN
        if (expOutValid && !out_ready && expStall < CMAX) expStall++;
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = CTRL_W'(d ^ 16'h05A5);
        out_ready = r;
        flush     = f;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        modelReset();
        rst = 1'b1;
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        #12;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_data", 32'(out_data), 32'd0);

        // Stream: four back-to-back instructions, 1-cycle latency, full rate.
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, DATA_W'(i), 1'b1, 1'b0);
            tick();
        end
        drive(1'b0, 16'h0000, 1'b1, 1'b0);
        tick();
        tick();

        // Backpressure: A and B fill both entries, C waits at the input.
        drive(1'b1, 16'h1111, 1'b0, 1'b0); tick();
        drive(1'b1, 16'h2222, 1'b0, 1'b0); tick();
        drive(1'b1, 16'h3333, 1'b0, 1'b0); tick();
        chk("bp_occ2", 32'(occupancy), 32'd2);
        chk("bp_inready0", 32'(in_ready), 32'd0);
        drive(1'b1, 16'h3333, 1'b1, 1'b0); tick();
        drive(1'b1, 16'h3333, 1'b1, 1'b0); tick();
        drive(1'b0, 16'h0000, 1'b1, 1'b0); tick();
        tick();

        // Flush at occupancy 2 with D offered: D must never appear.
        drive(1'b1, 16'h5555, 1'b0, 1'b0); tick();
        drive(1'b1, 16'h6666, 1'b0, 1'b0); tick();
        drive(1'b1, 16'h4444, 1'b0, 1'b1); tick();
        chk("fl_valid0", 32'(out_valid), 32'd0);
        chk("fl_ctrl0", 32'(out_ctrl), 32'd0);
        chk("fl_occ0", 32'(occupancy), 32'd0);
        chk("fl_inready1", 32'(in_ready), 32'd1);
        drive(1'b0, 16'h0000, 1'b1, 1'b0); tick();
        tick();

        // Simultaneous pop and accept at occupancy 1.
        drive(1'b1, 16'hE0E0, 1'b1, 1'b0); tick();
        drive(1'b1, 16'hF0F0, 1'b1, 1'b0); tick();
        chk("pa_occ1", 32'(occupancy), 32'd1);
        chk("pa_data", 32'(out_data), 32'hF0F0);
        drive(1'b0, 16'h0000, 1'b1, 1'b0); tick();

        // Asynchronous reset in the middle of a stalled transfer.
        drive(1'b1, 16'h7777, 1'b0, 1'b0); tick();
        drive(1'b1, 16'h8888, 1'b0, 1'b0); tick();
        #3;
        rst = 1'b1;
        #1;
        chk("rst_valid0", 32'(out_valid), 32'd0);
        chk("rst_ctrl0", 32'(out_ctrl), 32'd0);
        chk("rst_inready1", 32'(in_ready), 32'd1);
        chk("rst_occ0", 32'(occupancy), 32'd0);
        chk("rst_stall0", 32'(stall_cnt), 32'd0);
        modelReset();
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Counters: stall saturation and flush counting.
        drive(1'b1, 16'h9999, 1'b0, 1'b0); tick();
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tick();
`ifdef PIPE_STAGE_PERF_EN
        chk("stall_5", 32'(stall_cnt), 32'd5);
`else
        chk("stall_off", 32'(stall_cnt), 32'd0);
`endif
        for (int i = 0; i < 15; i++) tick();
`ifdef PIPE_STAGE_PERF_EN
        chk("stall_sat", 32'(stall_cnt), 32'd15);
`endif
        drive(1'b0, 16'h0000, 1'b0, 1'b1); tick();
        drive(1'b1, 16'hAAAA, 1'b0, 1'b0); tick();
        drive(1'b0, 16'h0000, 1'b0, 1'b1); tick();
        drive(1'b0, 16'h0000, 1'b0, 1'b1); tick();
        drive(1'b0, 16'h0000, 1'b1, 1'b0); tick();
`ifdef PIPE_STAGE_PERF_EN
        chk("flush_2", 32'(flush_cnt), 32'd2);
`else
        chk("flush_off", 32'(flush_cnt), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
